// File: rtl/afc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afc_pkg
// Description : Shared state encoding, mode encoding and code-range helpers
//               for the AFC SAR/track controller.
// Revision    : 1.0 - initial release
// ============================================================================
package afc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAILED  = 3'd4
    } afc_state_t;

    localparam logic AFC_MODE_SAR   = 1'b0;
    localparam logic AFC_MODE_TRACK = 1'b1;

    localparam int AFC_CODE_WIDTH = 8;

    // Helpers let any CODE_WIDTH derive its own midscale / all-ones constants.
    function automatic logic [63:0] afc_midscale(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] afc_all_ones(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

    localparam logic [AFC_CODE_WIDTH-1:0] AFC_MIDSCALE =
        AFC_CODE_WIDTH'(afc_midscale(AFC_CODE_WIDTH));
    localparam logic [AFC_CODE_WIDTH-1:0] AFC_ALL_ONES =
        AFC_CODE_WIDTH'(afc_all_ones(AFC_CODE_WIDTH));

endpackage
`default_nettype wire

// File: rtl/afc_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : afc_settle_timer
// Description : Shared cycle counter for the settle compare and the measure
//               timeout; cleared by load, saturates at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module afc_settle_timer #(
    parameter int SETTLE_W       = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] target,
    input  logic                mode_select,
    output logic                done
);

    localparam int c_TO_W  = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_CNT_W = (SETTLE_W > c_TO_W) ? SETTLE_W : c_TO_W;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE          = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // Saturation keeps an idle counter from wrapping back onto a compare value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign done = mode_select ? (r_count == c_TIMEOUT_LAST)
                              : (r_count == c_CNT_W'(target));

endmodule
`default_nettype wire

// File: rtl/afc_sar_tracker.sv
`default_nettype none
// ============================================================================
// Module      : afc_sar_tracker
// Description : AFC code controller with SAR search and +/-1 tracking modes,
//               settle delay, measurement timeout and lock/fail status.
// Revision    : 1.0 - initial release
// ============================================================================
module afc_sar_tracker
    import afc_pkg::*;
#(
    parameter int CODE_WIDTH      = 8,
    parameter int SETTLE_W        = 8,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int TRACK_MAX_STEPS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  afctrigger,
    input  logic                  mode,
    input  logic [SETTLE_W-1:0]   settle_cycles,
    input  logic                  meas_valid,
    input  logic                  gt_flag,
    input  logic                  lt_flag,
    input  logic                  eq_flag,
    output logic [CODE_WIDTH-1:0] control_code_out,
    output logic                  reset_counters,
    output logic                  busy,
    output logic                  afc_status,
    output logic                  afc_fail
);

    localparam logic [CODE_WIDTH-1:0] c_MIDSCALE = CODE_WIDTH'(afc_midscale(CODE_WIDTH));
    localparam logic [CODE_WIDTH-1:0] c_ALL_ONES = CODE_WIDTH'(afc_all_ones(CODE_WIDTH));
    localparam logic [CODE_WIDTH-1:0] c_CODE_ONE = CODE_WIDTH'(1);
    localparam int                    c_BIT_W    = $clog2(CODE_WIDTH);
    localparam logic [c_BIT_W-1:0]    c_TOP_BIT  = c_BIT_W'(CODE_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]    c_BIT_ONE  = c_BIT_W'(1);
    localparam int                    c_STEP_W   = $clog2(TRACK_MAX_STEPS + 1);
    localparam logic [c_STEP_W-1:0]   c_MAX_STEP = c_STEP_W'(TRACK_MAX_STEPS);
    localparam logic [c_STEP_W-1:0]   c_STEP_ONE = c_STEP_W'(1);

    afc_state_t            r_state, w_next_state;
    logic                  r_trig, r_trig_d;
    logic                  r_mode, w_mode;
    logic [SETTLE_W-1:0]   r_settle, w_settle;
    logic [CODE_WIDTH-1:0] r_code, w_code;
    logic                  r_rc, w_rc;
    logic                  r_status, w_status;
    logic                  r_fail, w_fail;
    logic [c_BIT_W-1:0]    r_bit, w_bit;
    logic [c_STEP_W-1:0]   r_steps, w_steps;
    logic                  r_dir_up, w_dir_up;
    logic                  r_dir_valid, w_dir_valid;

    logic w_start;
    logic w_any_flag;
    logic w_tmr_load;
    logic w_tmr_done;

    assign w_start    = r_trig & ~r_trig_d;
    assign w_any_flag = gt_flag | lt_flag | eq_flag;
    // Every state change restarts the shared counter from zero.
    assign w_tmr_load = (w_next_state != r_state);

    afc_settle_timer #(
        .SETTLE_W       (SETTLE_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_tmr_load),
        .target      (r_settle),
        .mode_select (r_state == ST_MEASURE),
        .done        (w_tmr_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_mode       = r_mode;
        w_settle     = r_settle;
        w_code       = r_code;
        w_rc         = 1'b0;
        w_status     = r_status;
        w_fail       = r_fail;
        w_bit        = r_bit;
        w_steps      = r_steps;
        w_dir_up     = r_dir_up;
        w_dir_valid  = r_dir_valid;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_status = 1'b0;
                    w_fail   = 1'b0;
                    w_mode   = mode;
                    w_settle = settle_cycles;
                    if (mode == AFC_MODE_SAR) begin
                        w_code = c_MIDSCALE;
                        w_bit  = c_TOP_BIT;
                    end else begin
                        w_steps     = '0;
                        w_dir_valid = 1'b0;
                    end
                    w_rc         = 1'b1;
                    w_next_state = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (!r_trig) begin
                    w_next_state = ST_IDLE;
                end else if (w_tmr_done) begin
                    w_next_state = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (!r_trig) begin
                    w_next_state = ST_IDLE;
                end else if (meas_valid && w_any_flag) begin
                    if (eq_flag) begin
                        w_status     = 1'b1;
                        w_next_state = ST_LOCKED;
                    end else if (r_mode == AFC_MODE_SAR) begin
                        w_code[r_bit] = gt_flag;
                        if (r_bit != '0) begin
                            w_code[r_bit - c_BIT_ONE] = 1'b1;
                            w_bit        = r_bit - c_BIT_ONE;
                            w_rc         = 1'b1;
                            w_next_state = ST_SETTLE;
                        end else begin
                            // Final decision may clear bit 0; only a real change loads the code.
                            w_rc         = (w_code != r_code);
                            w_status     = 1'b1;
                            w_next_state = ST_LOCKED;
                        end
                    end else if (r_dir_valid && (r_dir_up != gt_flag)) begin
                        w_status     = 1'b1;
                        w_next_state = ST_LOCKED;
                    end else if ((gt_flag && (r_code == c_ALL_ONES)) ||
                                 (!gt_flag && (r_code == '0)) ||
                                 (r_steps == c_MAX_STEP)) begin
                        w_fail       = 1'b1;
                        w_next_state = ST_FAILED;
                    end else begin
                        w_code       = gt_flag ? (r_code + c_CODE_ONE) : (r_code - c_CODE_ONE);
                        w_steps      = r_steps + c_STEP_ONE;
                        w_dir_up     = gt_flag;
                        w_dir_valid  = 1'b1;
                        w_rc         = 1'b1;
                        w_next_state = ST_SETTLE;
                    end
                end else if (w_tmr_done) begin
                    w_fail       = 1'b1;
                    w_next_state = ST_FAILED;
                end
            end

            ST_LOCKED, ST_FAILED: begin
                if (!r_trig) begin
                    w_status     = 1'b0;
                    w_fail       = 1'b0;
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_trig_d    <= 1'b0;
            r_mode      <= AFC_MODE_SAR;
            r_settle    <= '0;
            r_code      <= c_MIDSCALE;
            r_rc        <= 1'b0;
            r_status    <= 1'b0;
            r_fail      <= 1'b0;
            r_bit       <= c_TOP_BIT;
            r_steps     <= '0;
            r_dir_up    <= 1'b0;
            r_dir_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_trig      <= afctrigger;
            r_trig_d    <= r_trig;
            r_mode      <= w_mode;
            r_settle    <= w_settle;
            r_code      <= w_code;
            r_rc        <= w_rc;
            r_status    <= w_status;
            r_fail      <= w_fail;
            r_bit       <= w_bit;
            r_steps     <= w_steps;
            r_dir_up    <= w_dir_up;
            r_dir_valid <= w_dir_valid;
        end
    end

    assign control_code_out = r_code;
    assign reset_counters   = r_rc;
    assign afc_status       = r_status;
    assign afc_fail         = r_fail;
    assign busy             = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_afc_sar_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_afc_sar_tracker
// Description : Directed table-driven bench for afc_sar_tracker plus timeout,
//               abort and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afc_sar_tracker;

    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       afctrigger;
    logic       mode;
    logic [7:0] settle_cycles;
    logic       meas_valid;
    logic       gt_flag, lt_flag, eq_flag;
    logic [7:0] control_code_out;
    logic       reset_counters, busy, afc_status, afc_fail;

    int n_chk = 0;
    int n_err = 0;
    int rc_count = 0;

    afc_sar_tracker #(
        .CODE_WIDTH      (8),
        .SETTLE_W        (8),
        .TIMEOUT_CYCLES  (64),
        .TRACK_MAX_STEPS (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .afctrigger       (afctrigger),
        .mode             (mode),
        .settle_cycles    (settle_cycles),
        .meas_valid       (meas_valid),
        .gt_flag          (gt_flag),
        .lt_flag          (lt_flag),
        .eq_flag          (eq_flag),
        .control_code_out (control_code_out),
        .reset_counters   (reset_counters),
        .busy             (busy),
        .afc_status       (afc_status),
        .afc_fail         (afc_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && reset_counters === 1'b1) rc_count++;
    end

    typedef struct {
        bit         is_start;
        bit         md;
        logic [2:0] flags;   // {gt, lt, eq}
        logic [7:0] code;
        logic       rc;
        logic       status;
        logic       fail;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    function automatic logic [2:0] cmp(input logic [7:0] code, input logic [7:0] tgt);
        if (code == tgt) return EQ;
        else if (code < tgt) return GT;
        else return LT;
    endfunction

    function automatic vec_t vs(input bit md, input logic [7:0] code);
        vec_t v;
        v.is_start = 1'b1; v.md = md; v.flags = 3'b000;
        v.code = code; v.rc = 1'b1; v.status = 1'b0; v.fail = 1'b0;
        return v;
    endfunction

    function automatic vec_t vm(input logic [2:0] f, input logic [7:0] code,
                                input logic rc, input logic st, input logic fl);
        vec_t v;
        v.is_start = 1'b0; v.md = 1'b0; v.flags = f;
        v.code = code; v.rc = rc; v.status = st; v.fail = fl;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit md);
        int k;
        afctrigger = 1'b0;
        repeat (3) step();
        mode          = md;
        settle_cycles = 8'(SETTLE);
        afctrigger    = 1'b1;
        k = 0;
        while (reset_counters !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        chk1("start rc pulse", reset_counters, 1'b1);
    endtask

    task automatic do_meas(input logic [2:0] f);
        repeat (SETTLE + 1) step();
        meas_valid = 1'b1;
        {gt_flag, lt_flag, eq_flag} = f;
        step();
        meas_valid = 1'b0;
        {gt_flag, lt_flag, eq_flag} = 3'b000;
    endtask

    initial begin
        int rc_base;
        rst_n = 1'b0; afctrigger = 1'b0; mode = 1'b0; settle_cycles = 8'd0;
        meas_valid = 1'b0; gt_flag = 1'b0; lt_flag = 1'b0; eq_flag = 1'b0;

        // Run 1: SAR toward 0xA7
        vecs.push_back(vs(1'b0, 8'h80));
        vecs.push_back(vm(cmp(8'h80, 8'hA7), 8'hC0, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hC0, 8'hA7), 8'hA0, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hA0, 8'hA7), 8'hB0, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hB0, 8'hA7), 8'hA8, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hA8, 8'hA7), 8'hA4, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hA4, 8'hA7), 8'hA6, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hA6, 8'hA7), 8'hA7, 1, 0, 0));
        vecs.push_back(vm(cmp(8'hA7, 8'hA7), 8'hA7, 0, 1, 0));
        // Run 2: SAR to 0x40 as the track starting point
        vecs.push_back(vs(1'b0, 8'h80));
        vecs.push_back(vm(cmp(8'h80, 8'h40), 8'h40, 1, 0, 0));
        vecs.push_back(vm(cmp(8'h40, 8'h40), 8'h40, 0, 1, 0));
        // Run 3: track 0x40 -> 0x43, lock on reversal
        vecs.push_back(vs(1'b1, 8'h40));
        vecs.push_back(vm(GT, 8'h41, 1, 0, 0));
        vecs.push_back(vm(GT, 8'h42, 1, 0, 0));
        vecs.push_back(vm(GT, 8'h43, 1, 0, 0));
        vecs.push_back(vm(LT, 8'h43, 0, 1, 0));
        // Run 4: track step limit (4 steps allowed)
        vecs.push_back(vs(1'b1, 8'h43));
        vecs.push_back(vm(GT, 8'h44, 1, 0, 0));
        vecs.push_back(vm(GT, 8'h45, 1, 0, 0));
        vecs.push_back(vm(GT, 8'h46, 1, 0, 0));
        vecs.push_back(vm(GT, 8'h47, 1, 0, 0));
        vecs.push_back(vm(GT, 8'h47, 0, 0, 1));
        // Run 5: SAR with comparator always high, resolves to 0xFF on bit 0
        vecs.push_back(vs(1'b0, 8'h80));
        vecs.push_back(vm(GT, 8'hC0, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hE0, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hF0, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hF8, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hFC, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hFE, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hFF, 1, 0, 0));
        vecs.push_back(vm(GT, 8'hFF, 0, 1, 0));
        // Run 6: track saturation at all-ones
        vecs.push_back(vs(1'b1, 8'hFF));
        vecs.push_back(vm(GT, 8'hFF, 0, 0, 1));

        #12;
        chk8("reset code", control_code_out, 8'h80);
        chk1("reset rc", reset_counters, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset status", afc_status, 1'b0);
        chk1("reset fail", afc_fail, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        rc_base = rc_count;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_start) begin
                do_start(vecs[i].md);
                chk1($sformatf("row%0d busy", i), busy, 1'b1);
            end else begin
                // A measurement one cycle before MEASURE must be ignored.
                repeat (SETTLE) step();
                meas_valid = 1'b1;
                {gt_flag, lt_flag, eq_flag} = vecs[i].flags;
                step();
                meas_valid = 1'b0;
                {gt_flag, lt_flag, eq_flag} = 3'b000;
                chk8($sformatf("row%0d early-mv code", i), control_code_out, vecs[i-1].code);
                chk1($sformatf("row%0d early-mv rc", i), reset_counters, 1'b0);
                meas_valid = 1'b1;
                {gt_flag, lt_flag, eq_flag} = vecs[i].flags;
                step();
                meas_valid = 1'b0;
                {gt_flag, lt_flag, eq_flag} = 3'b000;
            end
            chk8($sformatf("row%0d code", i), control_code_out, vecs[i].code);
            chk1($sformatf("row%0d rc", i), reset_counters, vecs[i].rc);
            chk1($sformatf("row%0d status", i), afc_status, vecs[i].status);
            chk1($sformatf("row%0d fail", i), afc_fail, vecs[i].fail);
            if (i == 8) begin
                step();
                chk8("sar rc pulse count", 8'(rc_count - rc_base), 8'd8);
            end
        end

        // Measurement timeout: MEASURE lasts exactly 64 cycles
        do_start(1'b0);
        repeat (SETTLE + 64) step();
        chk1("timeout pre fail", afc_fail, 1'b0);
        chk1("timeout pre busy", busy, 1'b1);
        step();
        chk1("timeout fail", afc_fail, 1'b1);
        chk1("timeout busy", busy, 1'b0);
        chk8("timeout code", control_code_out, 8'h80);

        // Abort mid-SETTLE holds the code without status or fail
        do_start(1'b0);
        do_meas(GT);
        chk8("abort pre code", control_code_out, 8'hC0);
        step();
        afctrigger = 1'b0;
        repeat (3) step();
        chk1("abort busy", busy, 1'b0);
        chk1("abort status", afc_status, 1'b0);
        chk1("abort fail", afc_fail, 1'b0);
        chk8("abort code", control_code_out, 8'hC0);

        // Asynchronous reset in MEASURE, then a clean restart
        do_start(1'b0);
        do_meas(GT);
        repeat (SETTLE + 1) step();
        chk1("pre-reset busy", busy, 1'b1);
        #3 rst_n = 1'b0;
        afctrigger = 1'b0;
        #1;
        chk8("async rst code", control_code_out, 8'h80);
        chk1("async rst rc", reset_counters, 1'b0);
        chk1("async rst busy", busy, 1'b0);
        chk1("async rst status", afc_status, 1'b0);
        chk1("async rst fail", afc_fail, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(1'b0);
        chk8("restart code", control_code_out, 8'h80);
        do_meas(LT);
        chk8("restart step code", control_code_out, 8'h40);
        chk1("restart step rc", reset_counters, 1'b1);
        do_meas(EQ);
        chk1("restart lock", afc_status, 1'b1);
        chk8("restart lock code", control_code_out, 8'h40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
